// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with per-digit decimal point and blink.
// Latency: shadow registers update on the load edge; new values appear within one scan (4 slots).
// Backpressure: none; load is a single-cycle strobe that is accepted on every edge.
module seg_scan_driver #(
  parameter int SCAN_DIV    = 250000,
  parameter int BLINK_TICKS = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [CW-1:0] r_scan_cnt;
  logic [1:0]    r_digit;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic [15:0]   r_data;
  logic [3:0]    r_dp_mask;
  logic [3:0]    r_blink_mask;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_tick;
  logic          w_blink_wrap;
  logic [1:0]    w_next_digit;
  logic [3:0]    w_nibble;
  logic          w_blank;
  logic [6:0]    w_seg_dec;
  logic [3:0]    w_an_dec;

  // Segment patterns {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Slot tick, blink wrap and the decoded contents of the slot about to be shown.
  always_comb begin
    w_tick       = (r_scan_cnt == CW'(SCAN_DIV - 1));
    w_blink_wrap = (r_blink_cnt == BW'(BLINK_TICKS - 1));
    w_next_digit = r_digit + 2'd1;
    w_nibble     = r_data[{w_next_digit, 2'b00} +: 4];
    w_blank      = r_blink_phase & r_blink_mask[w_next_digit];
    w_seg_dec    = hex_to_seg(w_nibble);
    w_an_dec     = ~(4'b0001 << w_next_digit);
  end

  // Free-running slot counter; wraps on the tick cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
    end else if (w_tick) begin
      r_scan_cnt <= '0;
    end else begin
      r_scan_cnt <= r_scan_cnt + CW'(1);
    end
  end

  // Digit index starts at 3 so the first tick after reset lands on digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digit <= 2'd3;
    end else if (w_tick) begin
      r_digit <= w_next_digit;
    end
  end

  // Blink counter counts slot ticks; phase flips each time it wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_tick) begin
      if (w_blink_wrap) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  // Shadow registers; the display only ever reads these, never the live inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data       <= '0;
      r_dp_mask    <= '0;
      r_blink_mask <= '0;
    end else if (load) begin
      r_data       <= data_in;
      r_dp_mask    <= dp_mask;
      r_blink_mask <= blink_mask;
    end
  end

  // Output registers change only on a tick edge, using pre-edge shadow values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else if (w_tick) begin
      if (w_blank) begin
        r_an  <= 4'b1111;
        r_seg <= 7'b1111111;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= w_an_dec;
        r_seg <= w_seg_dec;
        r_dp  <= ~r_dp_mask[w_next_digit];
      end
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int BT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: edges since reset release plus the shadow contents.
  int          edges;
  logic [15:0] m_data;
  logic [3:0]  m_dpm;
  logic [3:0]  m_blm;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  seg_scan_driver #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in),
    .dp_mask(dp_mask), .blink_mask(blink_mask),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic model_reset();
    edges  = 0;
    m_data = '0;
    m_dpm  = '0;
    m_blm  = '0;
    e_an   = 4'b1111;
    e_seg  = 7'b1111111;
    e_dp   = 1'b1;
  endtask

  // One clock: drive inputs, advance the model across the edge, sample at +1.
  // Slot t (0-based) ends at edge (t+1)*SD, shows digit t%4, blink phase is (t/BT)%2.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dm, input logic [3:0] bm);
    int t;
    int dig;
    load = ld; data_in = d; dp_mask = dm; blink_mask = bm;
    @(posedge clk);
    edges++;
    if (edges % SD == 0) begin
      t   = edges / SD - 1;
      dig = t % 4;
      if (((t / BT) % 2) == 1 && m_blm[dig]) begin
        e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
      end else begin
        e_an = 4'b1111; e_an[dig] = 1'b0;
        e_seg = hex7(m_data[dig*4 +: 4]);
        e_dp  = ~m_dpm[dig];
      end
    end
    if (ld) begin
      m_data = d; m_dpm = dm; m_blm = bm;
    end
    #1;
    load = 1'b0;
  endtask

  task automatic step_idle();
    step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_async: an=%b seg=%b dp=%b, want 1111 1111111 1", an, seg, dp);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_release: an=%b seg=%b dp=%b, want blank", an, seg, dp);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 6 * SD * 4; i++) begin
      step_idle();
      vectors++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("FAIL idle edge%0d: got %b/%b/%b want %b/%b/%b", edges, an, seg, dp, e_an, e_seg, e_dp);
      end
      if (edges == SD) begin
        vectors++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
          miscompares++;
          $display("FAIL idle_first_tick: an=%b seg=%b, want 1110 1000000", an, seg);
        end
      end
    end
  endtask

  task automatic test_pattern();
    step(1'b1, 16'h1A80, 4'b0100, 4'b0000);
    for (int i = 0; i < 3 * SD * 4; i++) begin
      step_idle();
      vectors++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("FAIL pattern edge%0d: got %b/%b/%b want %b/%b/%b", edges, an, seg, dp, e_an, e_seg, e_dp);
      end
      if (an === 4'b1011) begin
        vectors++;
        if (seg !== 7'b0001000 || dp !== 1'b0) begin
          miscompares++;
          $display("FAIL pattern_digit2: seg=%b dp=%b, want 0001000 0", seg, dp);
        end
      end
    end
  endtask

  task automatic test_blink();
    step(1'b1, 16'($urandom), 4'($urandom), 4'b0101);
    for (int i = 0; i < 4 * SD * 4; i++) begin
      step_idle();
      vectors++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("FAIL blink edge%0d: got %b/%b/%b want %b/%b/%b", edges, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_load_on_tick();
    for (int i = 0; i < 4 * SD; i++) begin
      if (((edges + 1) % SD == 0) && (((edges + 1) / SD - 1) % 4 == 0)) break;
      step_idle();
    end
    step(1'b1, 16'hFFFF, 4'b0000, 4'b0000);
    vectors++;
    if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
      miscompares++;
      $display("FAIL load_on_tick_old: got %b/%b/%b want %b/%b/%b", an, seg, dp, e_an, e_seg, e_dp);
    end
    for (int i = 0; i < 4 * SD; i++) begin
      step_idle();
      vectors++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("FAIL load_on_tick edge%0d: got %b/%b/%b want %b/%b/%b", edges, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
    vectors++;
    if (an !== 4'b1110 || seg !== 7'b0001110) begin
      miscompares++;
      $display("FAIL load_on_tick_new: an=%b seg=%b, want 1110 0001110", an, seg);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 16'h8888, 4'b1111, 4'b0000);
    repeat (SD + 1) step_idle();
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_reset_blank: an=%b seg=%b dp=%b, want blank", an, seg, dp);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * SD * 4; i++) begin
      step_idle();
      vectors++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("FAIL mid_reset edge%0d: got %b/%b/%b want %b/%b/%b", edges, an, seg, dp, e_an, e_seg, e_dp);
      end
      if (edges == SD) begin
        vectors++;
        if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
          miscompares++;
          $display("FAIL mid_reset_restart: an=%b seg=%b dp=%b, want 1110 1000000 1", an, seg, dp);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 6) == 0, 16'($urandom), 4'($urandom), 4'($urandom));
      vectors++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("FAIL random edge%0d: got %b/%b/%b want %b/%b/%b", edges, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_pattern();
    test_blink();
    test_load_on_tick();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
